cpu_mem_bridge: RTL and testbench

- Parametrised successor to the fixed SRAM hookup at the CPU top: converts one CPU memory port (single-cycle, SRAM-style) into a request/address-ok/data-ok handshake bus with variable latency.
- Generates byte strobes and lane-replicated write data, checks alignment, stalls the pipeline, supports flush and a timeout.
- Instantiated once per port (instruction, data) between the datapath and the memory interconnect.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/mem_lane_gen.sv | 27 ++
 rtl/cpu_mem_bridge.sv | 101 ++++++++++
 tb/tb_cpu_mem_bridge.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: size encodings, bridge states, strobe and alignment helpers
package mem_bus_pkg;
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;

   // 8-byte strobe; narrower buses keep the low lanes
   function automatic logic [7:0] strb_of(input logic [1:0] size, input logic [2:0] off);
      logic [7:0] m;
      m = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0f : 8'hff;
      return m << off;
   endfunction

   function automatic logic misaligned_of(input logic [1:0] size, input logic [2:0] off, input logic wide);
      return size == SZ_H ? off[0] : size == SZ_W ? |off[1:0] : size == SZ_D ? (!wide || |off) : 1'b0;
   endfunction
endpackage

// File: rtl/mem_lane_gen.sv
// mem_lane_gen: byte strobes, lane-replicated store data and misalignment flag
module mem_lane_gen
   import mem_bus_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int NB = DATA_W / 8,
   localparam int OW = $clog2(NB)
) (
   input  logic [1:0]        size,
   input  logic [OW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [NB-1:0]     strb,
   output logic [DATA_W-1:0] rep,
   output logic              misaligned
);
   logic [2:0] off;
   logic [7:0] s8;
   assign off = 3'(addr);
   assign s8 = strb_of(size, off);
   assign strb = s8[NB-1:0];
   assign misaligned = misaligned_of(size, off, DATA_W == 64);
   for (genvar b = 0; b < NB; b++) begin : g_lane
      assign rep[8*b +: 8] = size == SZ_B ? wdata[7:0] :
                             size == SZ_H ? wdata[8*(b%2) +: 8] :
                             size == SZ_W ? wdata[8*(b%4) +: 8] : wdata[8*(b%8) +: 8];
   end
endmodule

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: single-cycle CPU memory port to addr_ok/data_ok handshake bus
// with alignment check, flush and data_ok timeout.
module cpu_mem_bridge
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256,
   localparam int NB = DATA_W / 8,
   localparam int OW = $clog2(NB)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [1:0]        cpu_size,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_flush,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_err,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [NB-1:0]     mem_strb,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata
);
   state_t state;
   logic [NB-1:0] strb;
   logic [DATA_W-1:0] rep;
   logic [31:0] cnt;
   logic mis, accept, tmo, drop;

   mem_lane_gen #(.DATA_W(DATA_W)) u_lane (
      .size(cpu_size), .addr(cpu_addr[OW-1:0]), .wdata(cpu_wdata),
      .strb(strb), .rep(rep), .misaligned(mis)
   );

   assign accept = state == IDLE && cpu_req && !mis && !cpu_flush;
   assign tmo = state == DATA && TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1) && !mem_data_ok;
   // the timed-out access is released in its error cycle, like a completion
   assign cpu_stall = accept || state == ADDR || (state == DATA && !tmo) || (state == DRAIN && cpu_req);
   assign cpu_err = !cpu_flush && ((state == IDLE && cpu_req && mis) || (tmo && !drop));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mem_req    <= 1'b0;
         mem_wr     <= 1'b0;
         mem_strb   <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_rdata  <= '0;
         cpu_rvalid <= 1'b0;
         drop       <= 1'b0;
         cnt        <= '0;
      end else begin
         cpu_rvalid <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               mem_req   <= 1'b1;
               mem_wr    <= cpu_wr;
               mem_strb  <= strb;
               mem_addr  <= {cpu_addr[ADDR_W-1:OW], {OW{1'b0}}};
               mem_wdata <= rep;
               drop      <= 1'b0;
               state     <= ADDR;
            end
            ADDR: begin
               drop <= drop || cpu_flush;
               cnt  <= '0;
               if (mem_addr_ok) begin
                  mem_req <= 1'b0;
                  state   <= mem_data_ok ? DONE : DATA;
               end
               if (mem_addr_ok && mem_data_ok) begin
                  cpu_rdata  <= mem_rdata;
                  cpu_rvalid <= !(drop || cpu_flush);
               end
            end
            DATA: begin
               drop <= drop || cpu_flush;
               cnt  <= cnt + 32'd1;
               if (mem_data_ok) begin
                  cpu_rdata  <= mem_rdata;
                  cpu_rvalid <= !(drop || cpu_flush);
                  state      <= DONE;
               end else if (tmo) state <= DRAIN;
            end
            DONE: state <= IDLE;
            DRAIN: if (mem_data_ok) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb_cpu_mem_bridge: directed tests on a 32-bit (TIMEOUT=8) and a 64-bit bridge
module tb_cpu_mem_bridge;
   logic clk = 1'b0, rst = 1'b0;
   logic wr = 1'b0, flush = 1'b0;
   logic [1:0] size = 2'd0;
   logic [31:0] addr = '0;
   logic [63:0] wdata = '0, rdata_in = '0;
   logic req_a = 1'b0, aok_a = 1'b0, dok_a = 1'b0;
   logic req_b = 1'b0, aok_b = 1'b0, dok_b = 1'b0;
   logic stall_a, rvalid_a, err_a, mreq_a, mwr_a;
   logic [3:0] strb_a;
   logic [31:0] maddr_a, mwdata_a, rdata_a;
   logic stall_b, rvalid_b, err_b, mreq_b, mwr_b;
   logic [7:0] strb_b;
   logic [31:0] maddr_b;
   logic [63:0] mwdata_b, rdata_b;
   int vec = 0, bad = 0;

   always #5 clk = ~clk;

   cpu_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_a (
      .clk(clk), .rst(rst), .cpu_req(req_a), .cpu_wr(wr), .cpu_size(size), .cpu_addr(addr),
      .cpu_wdata(wdata[31:0]), .cpu_flush(flush), .cpu_stall(stall_a), .cpu_rdata(rdata_a),
      .cpu_rvalid(rvalid_a), .cpu_err(err_a), .mem_req(mreq_a), .mem_wr(mwr_a), .mem_strb(strb_a),
      .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_addr_ok(aok_a), .mem_data_ok(dok_a),
      .mem_rdata(rdata_in[31:0])
   );

   cpu_mem_bridge #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(8)) u_b (
      .clk(clk), .rst(rst), .cpu_req(req_b), .cpu_wr(wr), .cpu_size(size), .cpu_addr(addr),
      .cpu_wdata(wdata), .cpu_flush(1'b0), .cpu_stall(stall_b), .cpu_rdata(rdata_b),
      .cpu_rvalid(rvalid_b), .cpu_err(err_b), .mem_req(mreq_b), .mem_wr(mwr_b), .mem_strb(strb_b),
      .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_addr_ok(aok_b), .mem_data_ok(dok_b),
      .mem_rdata(rdata_in)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #12;
      vec++; if ({stall_a, rvalid_a, err_a, mreq_a, mwr_a} !== 5'b0) begin bad++; $display("FAIL reset_ctl got %b want 00000", {stall_a, rvalid_a, err_a, mreq_a, mwr_a}); end
      vec++; if ({strb_a, maddr_a, mwdata_a, rdata_a} !== 100'b0) begin bad++; $display("FAIL reset_data got %h want 0", {strb_a, maddr_a, mwdata_a, rdata_a}); end
      vec++; if ({stall_b, rvalid_b, err_b, mreq_b, strb_b, rdata_b} !== 76'b0) begin bad++; $display("FAIL reset_wide got %h want 0", {stall_b, rvalid_b, err_b, mreq_b, strb_b, rdata_b}); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_word_load;
      req_a = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_1004;
      #1;
      vec++; if ({stall_a, mreq_a} !== 2'b10) begin bad++; $display("FAIL wl_c0 stall/mreq got %b want 10", {stall_a, mreq_a}); end
      tick();
      vec++; if ({stall_a, mreq_a, mwr_a, strb_a} !== 7'b110_1111) begin bad++; $display("FAIL wl_addr ctl got %b want 1101111", {stall_a, mreq_a, mwr_a, strb_a}); end
      vec++; if (maddr_a !== 32'h0000_1004) begin bad++; $display("FAIL wl_maddr got %h want 00001004", maddr_a); end
      aok_a = 1'b1;
      tick();
      aok_a = 1'b0;
      #1;
      vec++; if ({stall_a, mreq_a, rvalid_a} !== 3'b100) begin bad++; $display("FAIL wl_data1 got %b want 100", {stall_a, mreq_a, rvalid_a}); end
      tick();
      dok_a = 1'b1; rdata_in = 64'h0_DEADBEEF;
      #1;
      vec++; if ({stall_a, rvalid_a} !== 2'b10) begin bad++; $display("FAIL wl_data2 got %b want 10", {stall_a, rvalid_a}); end
      tick();
      dok_a = 1'b0; rdata_in = '0;
      #1;
      vec++; if ({stall_a, rvalid_a, err_a} !== 3'b010) begin bad++; $display("FAIL wl_done got %b want 010", {stall_a, rvalid_a, err_a}); end
      vec++; if (rdata_a !== 32'hDEADBEEF) begin bad++; $display("FAIL wl_rdata got %h want deadbeef", rdata_a); end
      tick();
      req_a = 1'b0;
      #1;
      vec++; if ({stall_a, rvalid_a, mreq_a} !== 3'b000) begin bad++; $display("FAIL wl_after got %b want 000", {stall_a, rvalid_a, mreq_a}); end
   endtask

   task automatic test_store;
      req_a = 1'b1; wr = 1'b1; size = 2'd0; addr = 32'h0000_1003; wdata = 64'h0_123456A5;
      tick();
      vec++; if ({mreq_a, mwr_a, strb_a} !== 6'b11_1000) begin bad++; $display("FAIL sb_ctl got %b want 111000", {mreq_a, mwr_a, strb_a}); end
      vec++; if (mwdata_a !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got %h want a5a5a5a5", mwdata_a); end
      vec++; if (maddr_a !== 32'h0000_1000) begin bad++; $display("FAIL sb_maddr got %h want 00001000", maddr_a); end
      aok_a = 1'b1; dok_a = 1'b1;
      tick();
      aok_a = 1'b0; dok_a = 1'b0;
      vec++; if ({rvalid_a, stall_a} !== 2'b10) begin bad++; $display("FAIL sb_done got %b want 10", {rvalid_a, stall_a}); end
      tick();
      size = 2'd1; addr = 32'h0000_1002; wdata = 64'h0_FFFF1234;
      tick();
      vec++; if ({mreq_a, mwr_a, strb_a} !== 6'b11_1100) begin bad++; $display("FAIL sh_ctl got %b want 111100", {mreq_a, mwr_a, strb_a}); end
      vec++; if (mwdata_a !== 32'h12341234) begin bad++; $display("FAIL sh_wdata got %h want 12341234", mwdata_a); end
      aok_a = 1'b1; dok_a = 1'b1;
      tick();
      aok_a = 1'b0; dok_a = 1'b0; req_a = 1'b0; wr = 1'b0;
      tick();
   endtask

   task automatic test_misaligned;
      req_a = 1'b1; size = 2'd1; addr = 32'h0000_1001;
      #1;
      vec++; if ({err_a, stall_a, mreq_a} !== 3'b100) begin bad++; $display("FAIL mis_half got %b want 100", {err_a, stall_a, mreq_a}); end
      tick();
      req_a = 1'b0;
      #1;
      vec++; if ({err_a, stall_a, mreq_a} !== 3'b000) begin bad++; $display("FAIL mis_after got %b want 000", {err_a, stall_a, mreq_a}); end
      req_a = 1'b1; size = 2'd3; addr = 32'h0000_1000;
      #1;
      vec++; if ({err_a, stall_a} !== 2'b10) begin bad++; $display("FAIL mis_dword32 got %b want 10", {err_a, stall_a}); end
      tick();
      req_a = 1'b0;
      tick();
   endtask

   task automatic test_flush;
      req_a = 1'b1; size = 2'd2; addr = 32'h0000_1008;
      tick();
      aok_a = 1'b1;
      tick();
      aok_a = 1'b0; flush = 1'b1;
      #1;
      vec++; if ({stall_a, err_a} !== 2'b10) begin bad++; $display("FAIL fl_data got %b want 10", {stall_a, err_a}); end
      tick();
      flush = 1'b0; dok_a = 1'b1; rdata_in = 64'h0_11111111;
      #1;
      vec++; if (stall_a !== 1'b1) begin bad++; $display("FAIL fl_sticky_stall got %b want 1", stall_a); end
      tick();
      dok_a = 1'b0; addr = 32'h0000_2000;
      #1;
      vec++; if ({rvalid_a, stall_a, mreq_a} !== 3'b000) begin bad++; $display("FAIL fl_done got %b want 000", {rvalid_a, stall_a, mreq_a}); end
      tick();
      vec++; if ({stall_a, mreq_a} !== 2'b10) begin bad++; $display("FAIL fl_next_accept got %b want 10", {stall_a, mreq_a}); end
      tick();
      vec++; if ({mreq_a, maddr_a} !== {1'b1, 32'h0000_2000}) begin bad++; $display("FAIL fl_next_req got %h want 100002000", {mreq_a, maddr_a}); end
      aok_a = 1'b1; dok_a = 1'b1; rdata_in = 64'h0_22222222;
      tick();
      aok_a = 1'b0; dok_a = 1'b0;
      vec++; if ({rvalid_a, rdata_a} !== {1'b1, 32'h22222222}) begin bad++; $display("FAIL fl_next_done got %h want 122222222", {rvalid_a, rdata_a}); end
      req_a = 1'b0;
      tick();
   endtask

   task automatic test_timeout;
      req_a = 1'b1; size = 2'd2; addr = 32'h0000_3000;
      tick();
      aok_a = 1'b1;
      tick();
      aok_a = 1'b0;
      for (int i = 1; i < 8; i++) begin
         #1;
         vec++; if ({err_a, stall_a} !== 2'b01) begin bad++; $display("FAIL to_wait%0d got %b want 01", i, {err_a, stall_a}); end
         tick();
      end
      vec++; if ({err_a, stall_a} !== 2'b10) begin bad++; $display("FAIL to_err got %b want 10", {err_a, stall_a}); end
      tick();
      addr = 32'h0000_3004;
      #1;
      vec++; if ({err_a, stall_a, mreq_a} !== 3'b010) begin bad++; $display("FAIL to_drain got %b want 010", {err_a, stall_a, mreq_a}); end
      tick();
      dok_a = 1'b1; rdata_in = 64'h0_BAD0BAD0;
      #1;
      vec++; if ({stall_a, mreq_a} !== 2'b10) begin bad++; $display("FAIL to_drain2 got %b want 10", {stall_a, mreq_a}); end
      tick();
      dok_a = 1'b0;
      #1;
      vec++; if ({rvalid_a, rdata_a} !== {1'b0, 32'h22222222}) begin bad++; $display("FAIL to_discard got %h want 022222222", {rvalid_a, rdata_a}); end
      vec++; if ({stall_a, mreq_a} !== 2'b10) begin bad++; $display("FAIL to_reaccept got %b want 10", {stall_a, mreq_a}); end
      tick();
      vec++; if ({mreq_a, maddr_a} !== {1'b1, 32'h0000_3004}) begin bad++; $display("FAIL to_next_req got %h want 100003004", {mreq_a, maddr_a}); end
      aok_a = 1'b1; dok_a = 1'b1; rdata_in = 64'h0_33333333;
      tick();
      aok_a = 1'b0; dok_a = 1'b0; req_a = 1'b0;
      vec++; if ({rvalid_a, rdata_a} !== {1'b1, 32'h33333333}) begin bad++; $display("FAIL to_next_done got %h want 133333333", {rvalid_a, rdata_a}); end
      tick();
   endtask

   task automatic test_wide;
      req_b = 1'b1; wr = 1'b1; size = 2'd3; addr = 32'h0000_2008; wdata = 64'h0123456789ABCDEF;
      #1;
      vec++; if ({stall_b, err_b} !== 2'b10) begin bad++; $display("FAIL w_dw_c0 got %b want 10", {stall_b, err_b}); end
      tick();
      vec++; if ({mreq_b, mwr_b, strb_b} !== 10'b11_1111_1111) begin bad++; $display("FAIL w_dw_strb got %b want 1111111111", {mreq_b, mwr_b, strb_b}); end
      vec++; if ({maddr_b, mwdata_b} !== {32'h0000_2008, 64'h0123456789ABCDEF}) begin bad++; $display("FAIL w_dw_data got %h want 000020080123456789abcdef", {maddr_b, mwdata_b}); end
      aok_b = 1'b1; dok_b = 1'b1;
      tick();
      aok_b = 1'b0; dok_b = 1'b0;
      vec++; if ({rvalid_b, stall_b} !== 2'b10) begin bad++; $display("FAIL w_dw_lat2 got %b want 10", {rvalid_b, stall_b}); end
      tick();
      addr = 32'h0000_2004;
      #1;
      vec++; if ({err_b, stall_b} !== 2'b10) begin bad++; $display("FAIL w_dw_mis got %b want 10", {err_b, stall_b}); end
      size = 2'd2;
      tick();
      vec++; if ({strb_b, mwdata_b} !== {8'hF0, 64'h89ABCDEF89ABCDEF}) begin bad++; $display("FAIL w_word_hi got %h want f089abcdef89abcdef", {strb_b, mwdata_b}); end
      aok_b = 1'b1; dok_b = 1'b1; rdata_in = 64'hCAFEF00D_12345678;
      tick();
      aok_b = 1'b0; dok_b = 1'b0; req_b = 1'b0; wr = 1'b0;
      vec++; if ({rvalid_b, rdata_b} !== {1'b1, 64'hCAFEF00D_12345678}) begin bad++; $display("FAIL w_rdata got %h want 1cafef00d12345678", {rvalid_b, rdata_b}); end
      tick();
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_store();
      test_misaligned();
      test_flush();
      test_timeout();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
